// File: rtl/clk_div_pwm.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pwm
// Purpose  : Samples divided clock levels as data, turns the selected one into
//            a tick that drives a glitch-free PWM with handshaked duty updates.
// Revision : 1.0
// ============================================================================
module clk_div_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div2_i,
  input  logic             clk_div4_i,
  input  logic             clk_div8_i,
  input  logic [1:0]       rate_sel_i,
  input  logic             duty_valid_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             duty_ready_o,
  output logic             tick_o,
  output logic             pwm_out_o,
  output logic             period_done_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             prev2_q, prev4_q, prev8_q;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_active_q, duty_active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             period_done_q, period_done_d;
  logic             rise2, rise4, rise8;
  logic             wrap;

  assign rise2 = clk_div2_i & ~prev2_q;
  assign rise4 = clk_div4_i & ~prev4_q;
  assign rise8 = clk_div8_i & ~prev8_q;
  assign wrap  = tick_q & (cnt_q == CNT_MAX);

  always_comb begin
    tick_d = 1'b0;
    case (rate_sel_i)
      2'd0:    tick_d = 1'b1;
      2'd1:    tick_d = rise2;
      2'd2:    tick_d = rise4;
      default: tick_d = rise8;
    endcase
  end

  // A shadow load can only occur while nothing is pending, so it never
  // collides with the wrap-time transfer into duty_active.
  always_comb begin
    cnt_d         = tick_q ? cnt_q + 1'b1 : cnt_q;
    period_done_d = wrap;
    pwm_d         = (cnt_q < duty_active_q);
    duty_active_d = duty_active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    if (wrap && pending_q) begin
      duty_active_d = shadow_q;
      pending_d     = 1'b0;
    end else if (duty_valid_i && !pending_q) begin
      shadow_d  = duty_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev2_q       <= 1'b0;
      prev4_q       <= 1'b0;
      prev8_q       <= 1'b0;
      tick_q        <= 1'b0;
      cnt_q         <= '0;
      duty_active_q <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      pwm_q         <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      prev2_q       <= clk_div2_i;
      prev4_q       <= clk_div4_i;
      prev8_q       <= clk_div8_i;
      tick_q        <= tick_d;
      cnt_q         <= cnt_d;
      duty_active_q <= duty_active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      pwm_q         <= pwm_d;
      period_done_q <= period_done_d;
    end
  end

  assign duty_ready_o  = ~pending_q;
  assign tick_o        = tick_q;
  assign pwm_out_o     = pwm_q;
  assign period_done_o = period_done_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_pwm
// Purpose  : Directed and randomized checks of clk_div_pwm against a model.
// Revision : 1.0
// ============================================================================
module tb_clk_div_pwm;
  localparam int W   = 4;
  localparam int PER = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d2 = 1'b0, d4 = 1'b0, d8 = 1'b0;
  logic [1:0]   rate_sel = 2'd0;
  logic         duty_valid = 1'b0;
  logic [W-1:0] duty = '0;
  logic         duty_ready, tick, pwm_out, period_done;

  int total = 0;
  int bad = 0;

  // Reference state in plain integers.
  int m_prev[3];
  int m_tick, m_cnt, m_act, m_shadow, m_pend, m_pwm, m_pd;
  logic [2:0] div_ctr = '0;
  int src_mode = 0;
  int win_high, win_pd, win_tick;

  always #5 clk = ~clk;

  clk_div_pwm #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_div2_i   (d2),
    .clk_div4_i   (d4),
    .clk_div8_i   (d8),
    .rate_sel_i   (rate_sel),
    .duty_valid_i (duty_valid),
    .duty_i       (duty),
    .duty_ready_o (duty_ready),
    .tick_o       (tick),
    .pwm_out_o    (pwm_out),
    .period_done_o(period_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_prev[i] = 0;
    m_tick = 0; m_cnt = 0; m_act = 0; m_shadow = 0;
    m_pend = 0; m_pwm = 0; m_pd = 0;
  endtask

  task automatic model_edge();
    int lv[3];
    int n_tick;
    int wrap;
    lv[0] = int'(d2); lv[1] = int'(d4); lv[2] = int'(d8);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (rate_sel == 2'd0) n_tick = 1;
    else n_tick = (lv[rate_sel-1] == 1 && m_prev[rate_sel-1] == 0) ? 1 : 0;
    wrap  = (m_tick == 1 && m_cnt == PER - 1) ? 1 : 0;
    m_pwm = (m_cnt < m_act) ? 1 : 0;
    m_pd  = wrap;
    if (m_tick == 1) m_cnt = (m_cnt + 1) % PER;
    if (wrap == 1 && m_pend == 1) begin
      m_act  = m_shadow;
      m_pend = 0;
    end else if (duty_valid && m_pend == 0) begin
      m_shadow = int'(duty);
      m_pend   = 1;
    end
    for (int i = 0; i < 3; i++) m_prev[i] = lv[i];
    m_tick = n_tick;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", tick, logic'(m_tick));
    chk("pwm_out", pwm_out, logic'(m_pwm));
    chk("period_done", period_done, logic'(m_pd));
    chk("duty_ready", duty_ready, logic'(m_pend == 0));
    win_high += int'(pwm_out);
    win_pd   += int'(period_done);
    win_tick += int'(tick);
    if (src_mode == 1) begin
      div_ctr = div_ctr + 3'd1;
      d2 = div_ctr[0]; d4 = div_ctr[1]; d8 = div_ctr[2];
    end else if (src_mode == 2) begin
      d2 = 1'($urandom); d4 = 1'($urandom); d8 = 1'($urandom);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_win();
    win_high = 0; win_pd = 0; win_tick = 0;
  endtask

  task automatic send_duty(input int v);
    duty = W'(v);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  initial begin
    int found;
    model_reset();
    clr_win();

    // Reset held with a request presented: nothing may be captured.
    duty_valid = 1'b1;
    duty = 4'h9;
    #1;
    chk("rst_tick", tick, 1'b0);
    chk("rst_ready", duty_ready, 1'b1);
    steps(3);
    @(posedge clk);
    #1;
    duty_valid = 1'b0;
    rst_n = 1'b1;

    // Every-clk rate, duty 4: first period dark, then 4 high of 16.
    rate_sel = 2'd0;
    send_duty(4);
    clr_win();
    steps(16);
    chk_int("first_period_high", win_high, 0);
    clr_win();
    steps(16);
    chk_int("duty4_high", win_high, 4);
    chk_int("duty4_pd", win_pd, 1);

    // Back-pressure: second request held until the shadow frees up.
    send_duty(3);
    duty = 4'd10;
    duty_valid = 1'b1;
    steps(40);
    duty_valid = 1'b0;
    steps(20);
    clr_win();
    steps(16);
    chk_int("duty10_high", win_high, 10);

    // Boundaries.
    send_duty(15);
    steps(40);
    clr_win();
    steps(16);
    chk_int("duty15_high", win_high, 15);
    send_duty(0);
    steps(40);
    clr_win();
    steps(16);
    chk_int("duty0_high", win_high, 0);

    // Divide-by-8 source from a real divider sequence.
    send_duty(5);
    rate_sel = 2'd3;
    src_mode = 1;
    steps(300);
    clr_win();
    steps(128);
    chk_int("div8_ticks", win_tick, 16);
    chk_int("div8_pd", win_pd, 1);
    chk_int("div8_high", win_high, 40);

    // Asynchronous reset at cnt = 7 with a duty pending.
    src_mode = 0;
    d2 = 1'b0; d4 = 1'b0; d8 = 1'b0;
    rate_sel = 2'd0;
    send_duty(9);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      duty = 4'd6;
      duty_valid = (m_pend == 0);
      step();
      duty_valid = 1'b0;
      if (m_cnt == 7 && m_pend == 1 && m_tick == 1) found = 1;
    end
    chk_int("reach_cnt7_pending", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tick", tick, 1'b0);
    chk("async_pwm", pwm_out, 1'b0);
    chk("async_pd", period_done, 1'b0);
    chk("async_ready", duty_ready, 1'b1);
    model_reset();
    step();
    rst_n = 1'b1;
    clr_win();
    steps(16);
    chk_int("post_rst_high", win_high, 0);
    chk_int("post_rst_pd", win_pd, 0);
    step();
    chk_int("post_rst_wrap", win_pd, 1);

    // Randomized traffic.
    src_mode = 2;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 100) src_mode = 1;
      if (i % 200 == 150) src_mode = 2;
      if ($urandom_range(0, 15) == 0) rate_sel = 2'($urandom);
      duty_valid = ($urandom_range(0, 3) == 0);
      duty = W'($urandom);
      step();
    end
    duty_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
